// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, op codes, FSM states and FIFO entry layout for the ALU op sequencer
package alu_seq_pkg;
  localparam int DATA_W = 4;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  typedef enum logic {ST_IDLE, ST_EXEC} state_e;
  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fifoEntry_t;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: synchronous command FIFO with wrap-around pointers and an extra pointer bit for full/empty
module op_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  fifoEntry_t             wrData,
  output fifoEntry_t             rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  fifoEntry_t mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wrPtr[AW-1:0]] <= wrData;
  assign empty  = wrPtr == rdPtr;
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign level  = wrPtr - rdPtr;
  assign rdData = mem[rdPtr[AW-1:0]];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, issues one per two cycles and registers each result behind a valid/ready slot
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [1:0]             in_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [1:0]             alu_s,
  input  logic [DATA_W-1:0]      alu_sum_sub,
  input  logic                   alu_carry_sub,
  input  logic                   alu_gt,
  input  logic                   alu_eq,
  input  logic                   alu_lt,
  input  logic [DATA_W-1:0]      alu_and,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic                   out_carry,
  output logic [2:0]             out_flags,
  output logic [1:0]             out_op,
  output logic [$clog2(DEPTH):0] fifo_level
);
  state_e     state, stateNext;
  logic       full, empty, push, pop;
  fifoEntry_t head;
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wrData ({in_op, in_a, in_b}),
    .rdData (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? ST_IDLE : stateNext;
  always_comb
    stateNext = (state == ST_EXEC) ? ST_IDLE : (pop ? ST_EXEC : ST_IDLE);
  always_comb
    pop = (state == ST_IDLE) && !empty && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= OP_NOP;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_flags  <= '0;
      out_op     <= OP_NOP;
    end else begin
      if (pop) begin
        alu_a <= head.a;
        alu_b <= head.b;
        alu_s <= head.op;
      end else if (state == ST_EXEC) begin
        alu_a <= '0;
        alu_b <= '0;
        alu_s <= OP_NOP;
      end
      if (state == ST_EXEC) begin
        out_valid  <= 1'b1;
        out_op     <= alu_s;
        out_result <= (alu_s == OP_SUB) ? alu_sum_sub : (alu_s == OP_AND) ? alu_and : '0;
        out_carry  <= (alu_s == OP_SUB) && alu_carry_sub;
        out_flags  <= (alu_s == OP_CMP) ? {alu_gt, alu_eq, alu_lt} : 3'b000;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural ALU closing the loop around the sequencer
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;
  localparam int DEPTH = 4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       inValid = 1'b0, outReady = 1'b0;
  logic [3:0] inA = '0, inB = '0;
  logic [1:0] inOp = '0;
  logic       inReady, outValid, outCarry;
  logic [3:0] aluA, aluB, aluSumSub, aluAnd, outResult;
  logic [1:0] aluS, outOp;
  logic       aluCarrySub, aluGt, aluEq, aluLt;
  logic [2:0] outFlags;
  logic [$clog2(DEPTH):0] fifoLevel;
  typedef struct {
    logic [1:0] op;
    logic [3:0] res;
    logic       carry;
    logic [2:0] flags;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0, lastXfer = -10, maxLevel = 0;
  logic       holdPrev = 1'b0;
  logic [9:0] prevOut;
  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .in_op(inOp),
    .alu_a(aluA), .alu_b(aluB), .alu_s(aluS),
    .alu_sum_sub(aluSumSub), .alu_carry_sub(aluCarrySub),
    .alu_gt(aluGt), .alu_eq(aluEq), .alu_lt(aluLt), .alu_and(aluAnd),
    .out_valid(outValid), .out_ready(outReady), .out_result(outResult),
    .out_carry(outCarry), .out_flags(outFlags), .out_op(outOp),
    .fifo_level(fifoLevel)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Behavioural ALU: each unit only drives while selected
  always_comb begin
    aluSumSub   = (aluS == OP_SUB) ? aluA - aluB : 4'h0;
    aluCarrySub = (aluS == OP_SUB) && (aluA >= aluB);
    aluGt       = (aluS == OP_CMP) && (aluA > aluB);
    aluEq       = (aluS == OP_CMP) && (aluA == aluB);
    aluLt       = (aluS == OP_CMP) && (aluA < aluB);
    aluAnd      = (aluS == OP_AND) ? aluA & aluB : 4'h0;
  end
  function automatic exp_t model(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    exp_t r;
    r.op = op; r.res = '0; r.carry = 1'b0; r.flags = '0;
    if (op == OP_SUB) begin r.res = a - b; r.carry = a >= b; end
    if (op == OP_CMP) r.flags = {a > b, a == b, a < b};
    if (op == OP_AND) r.res = a & b;
    return r;
  endfunction
  always @(negedge clk) begin
    if (int'(fifoLevel) > maxLevel) maxLevel = int'(fifoLevel);
    if (holdPrev && outValid) begin
      tests++;
      if ({outOp, outResult, outCarry, outFlags} !== prevOut) begin
        fails++;
        $display("FAIL hold: out fields %h changed from %h while stalled", {outOp, outResult, outCarry, outFlags}, prevOut);
      end
    end
    holdPrev = outValid && !outReady;
    prevOut  = {outOp, outResult, outCarry, outFlags};
    if (outValid && outReady) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL extra: unexpected result op=%b res=%h", outOp, outResult);
      end else begin
        e = sb.pop_front();
        if (outOp !== e.op || outResult !== e.res || outCarry !== e.carry || outFlags !== e.flags) begin
          fails++;
          $display("FAIL result: got op=%b res=%h c=%b f=%b, want op=%b res=%h c=%b f=%b",
                   outOp, outResult, outCarry, outFlags, e.op, e.res, e.carry, e.flags);
        end
      end
      tests++;
      if (cyc - lastXfer < 2) begin
        fails++;
        $display("FAIL rate: transfer gap %0d cycles, need >= 2", cyc - lastXfer);
      end
      lastXfer = cyc;
    end
  end
  task automatic send(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    int n = 0;
    inValid = 1'b1; inOp = op; inA = a; inB = b;
    while (!inReady && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b, need 1", inReady);
    end else begin
      sb.push_back(model(op, a, b));
      @(posedge clk); #1;
    end
    inValid = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || outValid) && n < 300) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, need 0", sb.size());
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0; outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({inReady, outValid, aluA, aluB, aluS, outResult, outCarry, outFlags, outOp, fifoLevel} !== '0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b alu=%h/%h/%b out=%h/%b/%b/%b lvl=%0d, need all 0",
               inReady, outValid, aluA, aluB, aluS, outResult, outCarry, outFlags, outOp, fifoLevel);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (inReady !== 1'b1) begin fails++; $display("FAIL reset_release: in_ready=%b, need 1", inReady); end
  endtask
  task automatic test_sub();
    outReady = 1'b1;
    send(OP_SUB, 4'd5, 4'd3);
    @(posedge clk); #1;
    tests++;
    if (aluS !== OP_SUB || aluA !== 4'd5 || aluB !== 4'd3 || outValid !== 1'b0) begin
      fails++;
      $display("FAIL sub_issue: alu_s=%b a=%h b=%h out_valid=%b, need 01/5/3/0", aluS, aluA, aluB, outValid);
    end
    @(posedge clk); #1;
    tests++;
    if (outValid !== 1'b1 || outResult !== 4'b0010 || outCarry !== 1'b1 || outFlags !== 3'b000 || aluS !== OP_NOP) begin
      fails++;
      $display("FAIL sub_latency: out_valid=%b res=%b c=%b f=%b alu_s=%b, need 1/0010/1/000/00",
               outValid, outResult, outCarry, outFlags, aluS);
    end
    wait_drain();
  endtask
  task automatic test_cmp_and();
    outReady = 1'b1;
    send(OP_CMP, 4'd9, 4'd9);
    send(OP_AND, 4'b1100, 4'b1010);
    send(OP_CMP, 4'd2, 4'd7);
    wait_drain();
  endtask
  task automatic test_backpressure();
    outReady = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send(OP_SUB, 4'(i + 8), 4'(i));
    tests++;
    if (inReady !== 1'b0 || int'(fifoLevel) != DEPTH || outValid !== 1'b1) begin
      fails++;
      $display("FAIL bp_full: in_ready=%b level=%0d out_valid=%b, need 0/%0d/1", inReady, fifoLevel, outValid, DEPTH);
    end
    inValid = 1'b1; inOp = OP_AND; inA = 4'hF; inB = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (inReady !== 1'b0 || int'(fifoLevel) != DEPTH) begin
        fails++;
        $display("FAIL bp_hold: in_ready=%b level=%0d, need 0/%0d", inReady, fifoLevel, DEPTH);
      end
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (aluS !== OP_SUB || aluA !== 4'd9 || outValid !== 1'b0 || int'(fifoLevel) != DEPTH - 1) begin
      fails++;
      $display("FAIL bp_release: alu_s=%b a=%h out_valid=%b level=%0d, need 01/9/0/%0d", aluS, aluA, outValid, fifoLevel, DEPTH - 1);
    end
    send(OP_AND, 4'hF, 4'h6);
    send(OP_CMP, 4'h1, 4'h0);
    wait_drain();
  endtask
  task automatic test_wrap();
    outReady = 1'b1;
    maxLevel = 0;
    for (int i = 0; i < 3 * DEPTH + 2; i++)
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    wait_drain();
    tests++;
    if (maxLevel != DEPTH) begin fails++; $display("FAIL wrap_full: max level %0d, need %0d", maxLevel, DEPTH); end
  endtask
  task automatic test_nop();
    int n = 0;
    outReady = 1'b1;
    fork
      begin
        send(OP_SUB, 4'd3, 4'd7);
        send(OP_NOP, 4'd6, 4'd2);
        send(OP_SUB, 4'd12, 4'd4);
      end
      repeat (14) begin
        @(posedge clk); #1;
        if (dut.state == ST_EXEC) begin
          n++;
          tests++;
          if (aluS !== ((n == 2) ? OP_NOP : OP_SUB)) begin
            fails++;
            $display("FAIL nop_exec: exec %0d alu_s=%b, need %b", n, aluS, (n == 2) ? OP_NOP : OP_SUB);
          end
        end
      end
    join
    tests++;
    if (n != 3) begin fails++; $display("FAIL nop_count: %0d exec cycles, need 3", n); end
    wait_drain();
  endtask
  task automatic test_reset_exec();
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) send(OP_SUB, 4'(i + 4), 4'(i));
    tests++;
    if (dut.state != ST_EXEC || int'(fifoLevel) != 2) begin
      fails++;
      $display("FAIL rst_setup: state=%0d level=%0d, need EXEC/2", dut.state, fifoLevel);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    tests++;
    if ({inReady, outValid, aluA, aluB, aluS, outResult, outCarry, outFlags, outOp, fifoLevel} !== '0) begin
      fails++;
      $display("FAIL rst_exec: in_ready=%b out_valid=%b alu=%h/%h/%b out=%h/%b/%b/%b lvl=%0d, need all 0",
               inReady, outValid, aluA, aluB, aluS, outResult, outCarry, outFlags, outOp, fifoLevel);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || fifoLevel !== '0) begin
      fails++;
      $display("FAIL rst_after: in_ready=%b out_valid=%b level=%0d, need 1/0/0", inReady, outValid, fifoLevel);
    end
    send(OP_AND, 4'hA, 4'h3);
    wait_drain();
  endtask
  initial begin
    test_reset();
    test_sub();
    test_cmp_and();
    test_backpressure();
    test_wrap();
    test_nop();
    test_reset_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
